// File: rtl/axi_wr_burst_engine.sv
// Single-burst AXI4 write master: issues one INCR burst, pulls each beat from a
// native read port into a one-entry holding register, then collects the B response.
module axi_wr_burst_engine #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_ADDR_W = ADDR_W,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned AXI_ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [AXI_LEN_W-1:0]    length,
  output logic                    ready,
  output logic                    error,
  output logic                    m_valid,
  output logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [DATA_W/8-1:0]     m_rstrb,
  input  logic                    m_ready,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [1:0]              m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE   = $clog2(STRB_W);
  localparam int unsigned CNT_W  = AXI_LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]       req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]       snd_cnt_q, snd_cnt_d;
  logic                   buf_full_q, buf_full_d;
  logic                   wvalid_q, wvalid_d;
  logic                   wlast_q, wlast_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic                   m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]      m_addr_q, m_addr_d;
  logic                   awvalid_q, awvalid_d;
  logic [AXI_ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic                   bready_q, bready_d;
  logic                   error_q, error_d;
  logic                   ready_q, ready_d;

  logic capture_c;
  logic w_hs_c;
  logic active_c;
  logic unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign capture_c = m_valid_q & m_ready;
  assign w_hs_c    = wvalid_q & m_axi_wready;

  // Next-state, beat request and holding-register control
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    snd_cnt_d  = snd_cnt_q;
    buf_full_d = buf_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    m_addr_d   = m_addr_q;
    m_valid_d  = 1'b0;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    bready_d   = bready_q;
    error_d    = error_q;
    ready_d    = ready_q;
    active_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          base_d     = addr;
          len_d      = length;
          awaddr_d   = AXI_ADDR_W'(addr);
          error_d    = 1'b0;
          req_cnt_d  = '0;
          snd_cnt_d  = '0;
          buf_full_d = 1'b0;
          ready_d    = 1'b0;
          awvalid_d  = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs_c && wlast_q) begin
          bready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          error_d  = |m_axi_bresp;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fill and a drain never coincide: requests only issue while the buffer is empty
    if (capture_c) begin
      wdata_d    = m_rdata;
      wstrb_d    = m_rstrb;
      buf_full_d = 1'b1;
      req_cnt_d  = req_cnt_q + CNT_W'(1);
    end else if (w_hs_c) begin
      buf_full_d = 1'b0;
      snd_cnt_d  = snd_cnt_q + CNT_W'(1);
    end

    active_c = (state_d == S_ADDR) || (state_d == S_DATA);
    if (m_valid_q && !m_ready) begin
      m_valid_d = 1'b1;
    end else if (active_c && !buf_full_d && (req_cnt_d <= CNT_W'(len_d))) begin
      m_valid_d = 1'b1;
      m_addr_d  = base_d + (ADDR_W'(req_cnt_d) << SIZE);
    end

    // W is only presented once the address phase is done, even if beat 0 was prefetched
    wvalid_d = (state_d == S_DATA) && buf_full_d;
    wlast_d  = wvalid_d && (snd_cnt_d == CNT_W'(len_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      snd_cnt_q  <= '0;
      buf_full_q <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      bready_q   <= 1'b0;
      error_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      snd_cnt_q  <= snd_cnt_d;
      buf_full_q <= buf_full_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      bready_q   <= bready_d;
      error_q    <= error_d;
      ready_q    <= ready_d;
    end
  end

  assign ready         = ready_q;
  assign error         = error_q;
  assign m_valid       = m_valid_q;
  assign m_addr        = m_addr_q;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Scoreboard bench for axi_wr_burst_engine: a native-read responder, a W-channel
// monitor against queued expected beats, and per-scenario tasks driving AW/B.
module tb_axi_wr_burst_engine;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] addr;
  logic [7:0]  length;
  logic        ready;
  logic        error;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic [3:0]  m_rstrb;
  logic        m_ready;
  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [1:0]  m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [0:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  wbeat_t      exp_w[$];
  logic [31:0] exp_maddr[$];
  int          tests = 0;
  int          fails = 0;
  int          served = 0;
  int          w_seen = 0;
  logic        aw_done = 1'b0;
  logic        saw_prev;
  logic [3:0]  wpat = 4'hF;
  int          widx;

  axi_wr_burst_engine dut (
    .clk(clk), .rst_n(rst_n), .run(run), .addr(addr), .length(length),
    .ready(ready), .error(error),
    .m_valid(m_valid), .m_addr(m_addr), .m_rdata(m_rdata), .m_rstrb(m_rstrb), .m_ready(m_ready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [3:0] beat_strb(input logic [31:0] a);
    return a[5:2] ^ 4'h9;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Native read responder: answers one cycle after it first sees m_valid
  initial begin
    m_ready = 1'b0; m_rdata = '0; m_rstrb = '0; saw_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_ready = 1'b0; saw_prev = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0;
      end else if (m_valid && saw_prev) begin
        saw_prev = 1'b0;
        served++;
        tests++;
        if (exp_maddr.size() == 0) begin
          fails++;
          $display("FAIL m_addr_unexpected: got request addr=%h, none expected", m_addr);
        end else begin
          if (m_addr !== exp_maddr[0]) begin
            fails++;
            $display("FAIL m_addr: got %h expected %h", m_addr, exp_maddr[0]);
          end
          void'(exp_maddr.pop_front());
        end
        m_ready = 1'b1;
        m_rdata = beat_data(m_addr);
        m_rstrb = beat_strb(m_addr);
      end else begin
        saw_prev = m_valid;
      end
    end
  end

  initial begin
    m_axi_wready = 1'b0; widx = 0;
    forever begin
      @(posedge clk); #1;
      m_axi_wready = wpat[widx[1:0]];
      widx++;
    end
  end

  // W monitor: every cycle wvalid is up, the presented beat must equal the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_axi_wvalid) begin
        tests++;
        if (!aw_done) begin
          fails++;
          $display("FAIL w_before_aw: got wvalid=1 before AW handshake, expected 0");
        end
        tests++;
        if (exp_w.size() == 0) begin
          fails++;
          $display("FAIL w_unexpected: got beat data=%h, none expected", m_axi_wdata);
        end else begin
          if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== exp_w[0]) begin
            fails++;
            $display("FAIL w_beat: got data=%h strb=%h last=%b expected data=%h strb=%h last=%b",
                     m_axi_wdata, m_axi_wstrb, m_axi_wlast,
                     exp_w[0].data, exp_w[0].strb, exp_w[0].last);
          end
          if (m_axi_wready) begin
            void'(exp_w.pop_front());
            w_seen++;
          end
        end
      end
    end
  end

  task automatic push_expect(input logic [31:0] a, input int len);
    wbeat_t b;
    logic [31:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba = a + 32'(4 * i);
      exp_maddr.push_back(ba);
      b.data = beat_data(ba);
      b.strb = beat_strb(ba);
      b.last = (i == len);
      exp_w.push_back(b);
    end
  endtask

  task automatic run_burst(input logic [31:0] a, input int len, input int stall,
                           input logic [1:0] br, input logic exp_err);
    int n;
    served = 0;
    aw_done = 1'b0;
    push_expect(a, len);
    run = 1'b1; addr = a; length = 8'(len);
    @(posedge clk); #1;
    run = 1'b0; addr = 32'hDEAD_BEE0; length = 8'hFF;
    tests++;
    if (ready !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL run_accept: got ready=%b error=%b expected ready=0 error=0", ready, error);
    end
    n = 0;
    while (!m_axi_awvalid && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== a || m_axi_awlen !== 8'(len)) begin
      fails++;
      $display("FAIL aw: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=%0d",
               m_axi_awvalid, m_axi_awaddr, m_axi_awlen, a, len);
    end
    for (int i = 0; i < stall; i++) begin
      run = (i == 0);
      @(posedge clk); #1;
      tests++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== a || m_axi_awlen !== 8'(len)) begin
        fails++;
        $display("FAIL aw_stall: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=%0d",
                 m_axi_awvalid, m_axi_awaddr, m_axi_awlen, a, len);
      end
    end
    run = 1'b0;
    if (stall >= 3) begin
      tests++;
      if (served != 1) begin
        fails++;
        $display("FAIL prefetch: got %0d requests during AW stall expected 1", served);
      end
    end
    m_axi_awready = 1'b1;
    @(posedge clk); #1;
    m_axi_awready = 1'b0;
    aw_done = 1'b1;
    n = 0;
    while (!m_axi_bready && n < 3000) begin @(posedge clk); #1; n++; end
    tests++;
    if (m_axi_bready !== 1'b1) begin
      fails++;
      $display("FAIL bready_timeout: got bready=%b expected 1", m_axi_bready);
    end
    m_axi_bresp = br; m_axi_bvalid = 1'b1;
    @(posedge clk); #1;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    tests++;
    if (ready !== 1'b1 || error !== exp_err || m_axi_bready !== 1'b0) begin
      fails++;
      $display("FAIL b_done: got ready=%b error=%b bready=%b expected ready=1 error=%b bready=0",
               ready, error, m_axi_bready, exp_err);
    end
    tests++;
    if (exp_w.size() != 0 || exp_maddr.size() != 0 || served != len + 1) begin
      fails++;
      $display("FAIL beat_count: got %0d requests, %0d W left, %0d addr left expected %0d, 0, 0",
               served, exp_w.size(), exp_maddr.size(), len + 1);
    end
    aw_done = 1'b0;
    exp_w.delete();
    exp_maddr.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({ready, error, m_valid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl: got ready/error/mvalid/awvalid/wvalid/wlast/bready=%b expected 1000000",
               {ready, error, m_valid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
    end
    tests++;
    if (m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0 || m_axi_wdata !== 32'h0 || m_axi_wstrb !== 4'h0) begin
      fails++;
      $display("FAIL reset_data: got awaddr=%h awlen=%h wdata=%h wstrb=%h expected all 0",
               m_axi_awaddr, m_axi_awlen, m_axi_wdata, m_axi_wstrb);
    end
    tests++;
    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}
        !== {1'b0, 3'd2, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000}) begin
      fails++;
      $display("FAIL aw_consts: got id=%b size=%0d burst=%b lock=%b cache=%b prot=%b qos=%b",
               m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_burst(32'h0000_0100, 3, 0, 2'b00, 1'b0);
  endtask

  task automatic test_single_beat();
    run_burst(32'h0000_0040, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_aw_stall();
    run_burst(32'h0000_0200, 2, 5, 2'b00, 1'b0);
  endtask

  task automatic test_w_stall();
    wpat = 4'b1001;
    run_burst(32'h0000_0300, 1, 0, 2'b00, 1'b0);
    run_burst(32'h0000_0380, 5, 0, 2'b00, 1'b0);
    wpat = 4'hF;
  endtask

  task automatic test_error();
    run_burst(32'h0000_0400, 1, 0, 2'b10, 1'b1);
    run_burst(32'h0000_0500, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    served = 0;
    w_seen = 0;
    aw_done = 1'b1;
    push_expect(32'h0000_0700, 3);
    run = 1'b1; addr = 32'h0000_0700; length = 8'd3;
    @(posedge clk); #1;
    run = 1'b0;
    m_axi_awready = 1'b1;
    n = 0;
    while (w_seen < 1 && n < 100) begin @(posedge clk); #1; n++; end
    m_axi_awready = 1'b0;
    tests++;
    if (w_seen != 1) begin
      fails++;
      $display("FAIL mid_progress: got %0d W beats before reset expected 1", w_seen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, m_valid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 6'b100000) begin
      fails++;
      $display("FAIL async_reset: got ready/mvalid/awvalid/wvalid/wlast/bready=%b expected 100000",
               {ready, m_valid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
    end
    exp_w.delete();
    exp_maddr.delete();
    aw_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(32'h0000_1000, 255, 0, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; addr = '0; length = '0;
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = '0;
    test_reset();
    test_basic();
    test_single_beat();
    test_aw_stall();
    test_w_stall();
    test_error();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
